// File: rtl/seg7_scan_ctl.sv
// Bus-mapped scan scheduler for a multiplexed 7-segment display: holds digit
// nibbles, steps digit strobes with a programmable dwell and on-time, per-digit blanking.
module seg7_scan_ctl #(
  parameter int          NDIGITS = 4,
  parameter logic [31:0] BASE    = 32'h10,
  parameter int          CW      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               rw,
  input  logic [31:0]        addr,
  input  logic [31:0]        d_in,
  output logic [31:0]        d_out,
  output logic [NDIGITS-1:0] an,
  output logic [3:0]         nib,
  output logic               frame
);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int DW = 4 * NDIGITS;

  // Shadow copies are bus-visible; active copies feed the scanner.
  logic [DW-1:0]      r_sh_data,   r_ac_data;
  logic [CW-1:0]      r_sh_dwell,  r_ac_dwell;
  logic [CW-1:0]      r_sh_ontime, r_ac_ontime;
  logic [NDIGITS-1:0] r_sh_blank,  r_ac_blank;
  logic               r_sh_en,     r_ac_en;

  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_idx;
  logic [NDIGITS-1:0] r_an;
  logic [3:0]         r_nib;
  logic               r_frame;
  logic [31:0]        r_dout;

  logic [31:0]        w_off;
  logic               w_hit, w_wr, w_rd;
  logic [31:0]        w_rdata;
  logic               w_bnd, w_load;
  logic [DW-1:0]      w_data_n;
  logic [CW-1:0]      w_dwell_n, w_ontime_n;
  logic [NDIGITS-1:0] w_blank_n;
  logic               w_en_n;
  logic [CW-1:0]      w_cnt_n;
  logic [IW-1:0]      w_idx_n;
  logic               w_frame_n;
  logic [NDIGITS-1:0] w_an_n;

  assign w_off = addr - BASE;
  assign w_hit = (w_off < 32'd3);
  assign w_wr  = enable && rw && w_hit;
  assign w_rd  = enable && !rw && w_hit;

  always_comb begin
    w_rdata = '0;
    case (w_off[1:0])
      2'd0: w_rdata[DW-1:0] = r_sh_data;
      2'd1: begin
        w_rdata[CW-1:0]  = r_sh_dwell;
        w_rdata[16 +: CW] = r_sh_ontime;
      end
      2'd2: begin
        w_rdata[NDIGITS-1:0] = r_sh_blank;
        w_rdata[31]          = r_sh_en;
      end
      default: w_rdata = '0;
    endcase
  end

  // Active copies only change at a slot boundary (or freely while stopped), so a
  // slot never shows a half-updated configuration.
  assign w_bnd      = r_ac_en && (r_cnt == r_ac_dwell);
  assign w_load     = w_bnd || !r_ac_en;
  assign w_data_n   = w_load ? r_sh_data   : r_ac_data;
  assign w_dwell_n  = w_load ? r_sh_dwell  : r_ac_dwell;
  assign w_ontime_n = w_load ? r_sh_ontime : r_ac_ontime;
  assign w_blank_n  = w_load ? r_sh_blank  : r_ac_blank;
  assign w_en_n     = w_load ? r_sh_en     : r_ac_en;

  always_comb begin
    w_cnt_n   = r_cnt + CW'(1);
    w_idx_n   = r_idx;
    w_frame_n = 1'b0;
    if (!w_en_n || !r_ac_en) begin
      w_cnt_n = '0;
      w_idx_n = '0;
    end else if (w_bnd) begin
      w_cnt_n = '0;
      if (r_idx == IW'(NDIGITS - 1)) begin
        w_idx_n   = '0;
        w_frame_n = 1'b1;
      end else begin
        w_idx_n = r_idx + IW'(1);
      end
    end
  end

  // Outputs are registered from next-state values so they line up with cnt/idx.
  always_comb begin
    w_an_n = '1;
    for (int k = 0; k < NDIGITS; k++) begin
      w_an_n[k] = !(w_en_n && (w_idx_n == IW'(k)) && !w_blank_n[w_idx_n] &&
                    (w_cnt_n < w_ontime_n));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_data   <= '0;
      r_sh_dwell  <= CW'(255);
      r_sh_ontime <= '1;
      r_sh_blank  <= '0;
      r_sh_en     <= 1'b1;
      r_ac_data   <= '0;
      r_ac_dwell  <= CW'(255);
      r_ac_ontime <= '1;
      r_ac_blank  <= '0;
      r_ac_en     <= 1'b1;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_an        <= '1;
      r_nib       <= '0;
      r_frame     <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_ac_data   <= w_data_n;
      r_ac_dwell  <= w_dwell_n;
      r_ac_ontime <= w_ontime_n;
      r_ac_blank  <= w_blank_n;
      r_ac_en     <= w_en_n;
      if (w_wr) begin
        case (w_off[1:0])
          2'd0: r_sh_data <= d_in[DW-1:0];
          2'd1: begin
            r_sh_dwell  <= d_in[CW-1:0];
            r_sh_ontime <= d_in[16 +: CW];
          end
          2'd2: begin
            r_sh_blank <= d_in[NDIGITS-1:0];
            r_sh_en    <= d_in[31];
          end
          default: ;
        endcase
      end
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_an    <= w_an_n;
      r_nib   <= w_data_n[{w_idx_n, 2'b00} +: 4];
      r_frame <= w_frame_n;
      r_dout  <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign d_out = r_dout;
  assign an    = r_an;
  assign nib   = r_nib;
  assign frame = r_frame;
endmodule

// File: tb/tb_seg7_scan_ctl.sv
// Bench for seg7_scan_ctl: directed test-plan steps plus random bus traffic,
// every cycle compared against a cycle model built from the register/scan rules.
module tb_seg7_scan_ctl;
  localparam logic [31:0] BASE = 32'h10;

  logic        clk = 1'b0;
  logic        reset, enable, rw;
  logic [31:0] addr, d_in;
  logic [31:0] d_out;
  logic [3:0]  an, nib;
  logic        frame;

  seg7_scan_ctl #(.NDIGITS(4), .BASE(BASE), .CW(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rw(rw), .addr(addr),
    .d_in(d_in), .d_out(d_out), .an(an), .nib(nib), .frame(frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] sh_data, ac_data, sh_dwell, ac_dwell, sh_ont, ac_ont;
  logic [3:0]  sh_blank, ac_blank;
  logic        sh_en, ac_en;
  int          m_cnt, m_idx;
  logic [3:0]  e_an, e_nib;
  logic        e_fr;
  logic [31:0] e_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] off);
    case (off)
      32'd0:   return {16'h0, sh_data};
      32'd1:   return {sh_ont, sh_dwell};
      32'd2:   return {sh_en, 27'h0, sh_blank};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] off;
    logic        inr, bnd, was_en;
    if (reset) begin
      sh_data = 0; ac_data = 0; sh_dwell = 255; ac_dwell = 255;
      sh_ont = 16'hFFFF; ac_ont = 16'hFFFF; sh_blank = 0; ac_blank = 0;
      sh_en = 1; ac_en = 1; m_cnt = 0; m_idx = 0;
      e_an = 4'hF; e_nib = 0; e_fr = 0; e_dout = 0;
      return;
    end
    off    = addr - BASE;
    inr    = off < 3;
    e_dout = (enable && !rw && inr) ? rd_val(off) : 32'h0;
    bnd    = ac_en && (m_cnt == int'(ac_dwell));
    was_en = ac_en;
    if (bnd || !ac_en) begin
      ac_data = sh_data; ac_dwell = sh_dwell; ac_ont = sh_ont;
      ac_blank = sh_blank; ac_en = sh_en;
    end
    e_fr = 0;
    if (!ac_en || !was_en) begin
      m_cnt = 0; m_idx = 0;
    end else if (bnd) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
      e_fr  = (m_idx == 0);
    end else begin
      m_cnt = (m_cnt + 1) % 65536;
    end
    if (enable && rw && inr) begin
      case (off)
        32'd0: sh_data = d_in[15:0];
        32'd1: begin sh_dwell = d_in[15:0]; sh_ont = d_in[31:16]; end
        default: begin sh_blank = d_in[3:0]; sh_en = d_in[31]; end
      endcase
    end
    e_an = 4'hF;
    if (ac_en && !ac_blank[m_idx] && m_cnt < int'(ac_ont)) e_an[m_idx] = 1'b0;
    e_nib = ac_data[4*m_idx +: 4];
  endtask

  task automatic cyc(input logic r, input logic e, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    reset = r; enable = e; rw = w; addr = a; d_in = d;
    @(posedge clk);
    model_edge();
    #1;
    check("an",    {28'h0, an},    {28'h0, e_an});
    check("nib",   {28'h0, nib},   {28'h0, e_nib});
    check("frame", {31'h0, frame}, {31'h0, e_fr});
    check("d_out", d_out, e_dout);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, BASE + 32'(off), d);
  endtask

  task automatic rd(input int off);
    cyc(1'b0, 1'b1, 1'b0, BASE + 32'(off), 32'h0);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      idle();
      n++;
    end while (frame !== 1'b1 && n < 3000);
    check(tag, {31'h0, frame}, 32'h1);
  endtask

  initial begin
    int frames;
    logic [3:0] ea;

    // Reset and idle scanning with DWELL=255
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_an",  {28'h0, an},  32'hF);
    check("rst_nib", {28'h0, nib}, 32'h0);
    check("rst_frm", {31'h0, frame}, 32'h0);
    check("rst_do",  d_out, 32'h0);
    frames = 0;
    idle();
    check("cyc1_an", {28'h0, an}, 32'hE);
    for (int t = 2; t <= 256; t++) begin idle(); if (frame) frames++; end
    check("cyc256_an", {28'h0, an}, 32'hD);
    for (int t = 257; t <= 2048; t++) begin idle(); if (frame) frames++; end
    check("frames_2048", 32'(frames), 32'd2);

    // DATA=4321, DWELL=3: nib 1..4 with an walking low
    wr(0, 32'h4321);
    wr(1, 32'hFFFF0003);
    wait_frame("frm_4321");
    for (int k = 0; k < 16; k++) begin
      if (k > 0) idle();
      ea = ~(4'b0001 << (k / 4));
      check("seq_nib", {28'h0, nib}, 32'(k / 4 + 1));
      check("seq_an",  {28'h0, an},  {28'h0, ea});
    end

    // ONTIME=2: lit for cnt 0,1 only
    wr(1, 32'h00020003);
    wait_frame("frm_ont2");
    for (int k = 0; k < 16; k++) begin
      if (k > 0) idle();
      ea = ((k % 4) < 2) ? ~(4'b0001 << (k / 4)) : 4'hF;
      check("ont2_an", {28'h0, an}, {28'h0, ea});
    end
    rd(1);
    check("rd_ctrl", d_out, 32'h00020003);
    rd(3);
    check("rd_oob", d_out, 32'h0);
    rd(-1);
    check("rd_below", d_out, 32'h0);

    // ONTIME=0: permanently dark
    wr(1, 32'h00000003);
    wait_frame("frm_ont0");
    for (int k = 0; k < 8; k++) begin
      idle();
      check("ont0_an", {28'h0, an}, 32'hF);
    end

    // Blank digit 2
    wr(1, 32'hFFFF0003);
    wr(2, 32'h80000004);
    wait_frame("frm_blank");
    for (int k = 0; k < 16; k++) begin
      if (k > 0) idle();
      ea = (k / 4 == 2) ? 4'hF : ~(4'b0001 << (k / 4));
      check("blank_an",  {28'h0, an},  {28'h0, ea});
      check("blank_nib", {28'h0, nib}, 32'(k / 4 + 1));
    end

    // Write landing exactly on a boundary is deferred by one slot
    wr(2, 32'h80000000);
    wr(0, 32'h5555);
    wait_frame("frm_5555");
    for (int n = 0; n < 10 && m_cnt != int'(ac_dwell); n++) idle();
    wr(0, 32'hAAAA);
    check("bnd_nib_old", {28'h0, nib}, 32'h5);
    for (int k = 0; k < 3; k++) begin idle(); check("bnd_nib_old", {28'h0, nib}, 32'h5); end
    for (int k = 0; k < 4; k++) begin idle(); check("bnd_nib_new", {28'h0, nib}, 32'hA); end

    // Disable, then re-enable
    wr(2, 32'h0);
    for (int n = 0; n < 10 && ac_en; n++) idle();
    for (int k = 0; k < 4; k++) begin idle(); check("dis_an", {28'h0, an}, 32'hF); end
    wr(2, 32'h80000000);
    check("reen_an0", {28'h0, an}, 32'hF);
    idle();
    check("reen_an1", {28'h0, an}, 32'hE);
    check("reen_nib", {28'h0, nib}, 32'hA);

    // Random bus traffic including mid-scan resets
    for (int i = 0; i < 4000; i++) begin
      int r, off;
      logic [31:0] d;
      r   = $urandom_range(0, 99);
      off = $urandom_range(0, 4) - 1;
      d   = $urandom;
      if (off == 1) d = {16'($urandom_range(0, 8)), 16'($urandom_range(0, 6))};
      if (off == 2) d[31] = ($urandom_range(0, 4) != 0);
      if (r < 2)       cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      else if (r < 12) wr(off, d);
      else if (r < 25) rd(off);
      else             idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctl.md
Name: seg7_scan_ctl

Overview:
- Bus-mapped scan scheduler for the multiplexed 4-digit 7-segment display.
- Holds the digit nibbles and sequences digit strobes with a programmable dwell time.
- Supports per-digit blanking and on-time (brightness) control.
- Drives the common-anode enables and the current nibble, which go to the existing hex-to-ASCII and segment lookup path.
- Sits on the same system bus as other memory-mapped devices.

Parameters:
- NDIGITS, 4, number of multiplexed digits (2..8).
- BASE, 32'h10, word address of register 0.
- CW, 16, width of dwell/on-time counters.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  bus cycle valid
- rw  in  1  1 = write, 0 = read
- addr  in  32  word address
- d_in  in  32  write data
- d_out  out  32  read data, registered
- an  out  NDIGITS  digit enables, active low
- nib  out  4  nibble of currently strobed digit
- frame  out  1  one-cycle strobe at start of each scan frame

Behaviour:
- Register map (addr - BASE); any other address is ignored, reads 0:
  - 0 DATA: [4*NDIGITS-1:0], digit i at [4i+:4].
  - 1 CTRL: [CW-1:0] DWELL (slot length = DWELL+1 cycles); [16+CW-1:16] ONTIME.
  - 2 MASK: [NDIGITS-1:0] blank bits (1 = digit dark); [31] SCAN_EN.
- Unimplemented bits: written bits are discarded; they read 0.
- Each register has a shadow copy (bus-visible) and an active copy (used by the scanner).
- Write: enable && rw && in range updates the shadow on that clk edge.
- Read: enable && !rw && in range -> d_out = shadow value on the next cycle. In all other cycles d_out = 0.
- Reset values:
  - Shadow and active: DATA = 0, DWELL = 255, ONTIME = all ones, MASK blank = 0, SCAN_EN = 1.
  - Internal state: cnt = 0, idx = 0.
  - Outputs: an = all 1, nib = 0, frame = 0, d_out = 0.
- Scanner state: cnt (CW bits), idx (0..NDIGITS-1).
  - Each cycle with SCAN_EN active = 1: if cnt == DWELL_active (boundary), then cnt <= 0 and idx <= idx+1, with NDIGITS-1 wrapping to 0. Otherwise cnt <= cnt+1.
  - If DWELL_active is lowered below the current cnt, cnt continues upward, wraps through 2^CW-1 -> 0, then meets DWELL normally.
- Active registers load from shadows only at a boundary, and on every cycle while SCAN_EN active = 0.
  - A write in the same cycle as a boundary is NOT taken at that boundary; it takes effect at the next one.
  - This rule prevents mid-slot tearing.
- Disabled state (SCAN_EN active = 0): cnt and idx held at 0, an = all 1, frame = 0.
  - Re-enable takes effect when the shadow is copied (next cycle).
  - Scan resumes at digit 0 with cnt = 0.
- Outputs are registered and computed from the next-state cnt/idx, so they align with the cnt/idx of the same cycle:
  - an[k] = 0 iff SCAN_EN && k == idx && !blank[idx] && cnt < ONTIME.
  - ONTIME = 0 gives permanently dark. ONTIME > DWELL gives full on.
  - nib = DATA_active[4*idx+:4], updated even when blanked.
  - frame = 1 in the cycle where idx becomes 0 with cnt = 0 after a wrap. Not asserted on the first cycle after reset.
- Reset mid-scan: all state and outputs return to reset values on that edge. Pending shadow writes are lost.
- Exactly one an bit low at most in any cycle.

Test Plan:
- Reset then idle:
  - Cycle 1 after reset: an=1110, nib=0.
  - an steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, every 256 cycles.
  - frame pulses once per 1024 cycles.
- Write DATA=16'h4321, CTRL={ONTIME=16'hFFFF, DWELL=3}:
  - After the next boundary, each digit is held 4 cycles.
  - nib sequence 1,2,3,4 aligned with an 1110,1101,1011,0111.
- CTRL ONTIME=2, DWELL=3: per slot, an bit low for cnt 0,1 and all-ones for cnt 2,3. ONTIME=0 -> an stays 1111.
- MASK blank=4'b0100: slot for digit 2 shows an=1111 while nib=DATA[11:8]. Other digits are unaffected.
- Write DATA=16'hAAAA in the exact boundary cycle, with prior DATA 16'h5555:
  - Following slot still shows nib=5.
  - nib=A from the subsequent slot onward.
- Read and range checks:
  - Read addr BASE+1 after the above write -> d_out=32'h00020003 one cycle later.
  - Read BASE+3 -> 0.
  - SCAN_EN=0 write -> an=1111, cnt/idx=0. Re-enable -> an=1110.
